rob_recovery_walker: RTL and testbench

- ROB-side responder to the recovery controller's misprediction and store-set-violation protocol.
- Captures the squash boundary at `recovery_start` and broadcasts the squashed ROB tag range during the flush cycle.
- During rollback, walks squashed entries youngest-first, two per cycle, restoring RAT mappings and returning physical registers to the freelist.
- Asserts `ROB_recovery_finished` to end the controller's ROLL_BACK state.

---
 rtl/rob_recovery_walker_pkg.sv | 24 ++
 rtl/rob_recovery_range_calc.sv | 22 ++
 rtl/rob_recovery_walker.sv | 157 +++++++++++++++
 tb/tb_rob_recovery_walker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_recovery_walker_pkg.sv
// rtl/rob_recovery_walker_pkg.sv - shared sizes, types and FSM states for the ROB recovery walker
package rob_recovery_walker_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int ARCH_W    = 5;
    localparam int PREG_W    = 6;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic              wen;
        logic [ARCH_W-1:0] arch;
        logic [PREG_W-1:0] old_preg;
        logic [PREG_W-1:0] new_preg;
    } rob_walk_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WALK  = 2'd2
    } recovery_walk_state_t;

endpackage

// File: rtl/rob_recovery_range_calc.sv
// rtl/rob_recovery_range_calc.sv - squash boundary and squashed-entry count from the offending tag
module rob_recovery_range_calc #(
    parameter int ROB_DEPTH = 32,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic [TAG_W-1:0] recovery_tag,
    input  logic             recovery_inclusive,
    input  logic [TAG_W-1:0] rob_tail,
    input  logic             rob_full,
    output logic [TAG_W-1:0] boundary,
    output logic [TAG_W:0]   remaining
);

    logic [TAG_W-1:0] span;

    assign boundary = recovery_inclusive ? recovery_tag : recovery_tag + TAG_W'(1);
    assign span     = rob_tail - boundary;

    // A full ROB with tail on the boundary means every entry is squashed, not none.
    assign remaining = (rob_full && span == '0) ? (TAG_W+1)'(ROB_DEPTH) : {1'b0, span};

endmodule

// File: rtl/rob_recovery_walker.sv
// rtl/rob_recovery_walker.sv - ROB-side squash range broadcast and two-wide youngest-first rollback walk
// Optional statistics counters: RECOVERY_WALK_STATS_EN
module rob_recovery_walker
    import rob_recovery_walker_pkg::*;
#(
    parameter int ROB_DEPTH = rob_recovery_walker_pkg::ROB_DEPTH,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int ARCH_W    = rob_recovery_walker_pkg::ARCH_W,
    parameter int PREG_W    = rob_recovery_walker_pkg::PREG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              recovery_start,
    input  logic [TAG_W-1:0]  recovery_tag,
    input  logic              recovery_inclusive,
    input  logic [TAG_W-1:0]  rob_tail,
    input  logic              rob_full,
    input  logic              recovery_flush,
    input  logic              recovery_rollback,
    output logic [TAG_W-1:0]  rob_rd_tag_0,
    output logic [TAG_W-1:0]  rob_rd_tag_1,
    input  logic              rob_rd_wen_0,
    input  logic              rob_rd_wen_1,
    input  logic [ARCH_W-1:0] rob_rd_arch_0,
    input  logic [ARCH_W-1:0] rob_rd_arch_1,
    input  logic [PREG_W-1:0] rob_rd_old_preg_0,
    input  logic [PREG_W-1:0] rob_rd_old_preg_1,
    input  logic [PREG_W-1:0] rob_rd_new_preg_0,
    input  logic [PREG_W-1:0] rob_rd_new_preg_1,
    output logic [TAG_W-1:0]  flush_rob_tag_0,
    output logic [TAG_W-1:0]  flush_rob_tag_1,
    output logic              flush_rob_tag_0_valid,
    output logic              flush_rob_tag_1_valid,
    output logic              rat_restore_valid_0,
    output logic              rat_restore_valid_1,
    output logic [ARCH_W-1:0] rat_restore_arch_0,
    output logic [ARCH_W-1:0] rat_restore_arch_1,
    output logic [PREG_W-1:0] rat_restore_preg_0,
    output logic [PREG_W-1:0] rat_restore_preg_1,
    output logic              fl_return_valid_0,
    output logic              fl_return_valid_1,
    output logic [PREG_W-1:0] fl_return_preg_0,
    output logic [PREG_W-1:0] fl_return_preg_1,
    output logic              rob_tail_restore_valid,
    output logic [TAG_W-1:0]  rob_tail_restore,
`ifdef RECOVERY_WALK_STATS_EN
    output logic [31:0]       stat_recoveries,
    output logic [31:0]       stat_walk_cycles,
`endif
    output logic              ROB_recovery_finished
);

    localparam logic [TAG_W:0] CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W:0] CNT_TWO = (TAG_W+1)'(2);

    recovery_walk_state_t state_q, state_d;
    logic [TAG_W-1:0]     boundary_q, walk_ptr_q, boundary_c;
    logic [TAG_W:0]       remaining_q, remaining_c, step;
    logic                 accept, active, slot0_live, slot1_live, finish, flushing;
    rob_walk_entry_t      entry_0, entry_1;

    rob_recovery_range_calc #(
        .ROB_DEPTH(ROB_DEPTH),
        .TAG_W    (TAG_W)
    ) u_range_calc (
        .recovery_tag      (recovery_tag),
        .recovery_inclusive(recovery_inclusive),
        .rob_tail          (rob_tail),
        .rob_full          (rob_full),
        .boundary          (boundary_c),
        .remaining         (remaining_c)
    );

    assign accept = (state_q == ST_IDLE) && recovery_start;

    // The first rollback cycle in ARMED already walks, so ARMED and WALK share the datapath.
    assign active     = (state_q == ST_ARMED || state_q == ST_WALK) && recovery_rollback;
    assign slot0_live = active && (remaining_q != '0);
    assign slot1_live = active && (remaining_q >= CNT_TWO);
    assign step       = slot1_live ? CNT_TWO : (slot0_live ? CNT_ONE : '0);
    assign finish     = active && (remaining_q <= CNT_TWO);
    assign flushing   = (state_q == ST_ARMED) && recovery_flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (recovery_start) state_d = ST_ARMED;
            ST_ARMED: if (active) state_d = finish ? ST_IDLE : ST_WALK;
            ST_WALK:  if (finish) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            boundary_q  <= '0;
            walk_ptr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                boundary_q  <= boundary_c;
                remaining_q <= remaining_c;
                walk_ptr_q  <= rob_tail - TAG_W'(1);
            end else if (active) begin
                walk_ptr_q  <= walk_ptr_q - step[TAG_W-1:0];
                remaining_q <= remaining_q - step;
            end
        end
    end

    assign entry_0 = '{wen: rob_rd_wen_0, arch: rob_rd_arch_0,
                       old_preg: rob_rd_old_preg_0, new_preg: rob_rd_new_preg_0};
    assign entry_1 = '{wen: rob_rd_wen_1, arch: rob_rd_arch_1,
                       old_preg: rob_rd_old_preg_1, new_preg: rob_rd_new_preg_1};

    assign rob_rd_tag_0 = walk_ptr_q;
    assign rob_rd_tag_1 = walk_ptr_q - TAG_W'(1);

    assign flush_rob_tag_0       = flushing ? boundary_q : '0;
    assign flush_rob_tag_1       = flushing ? walk_ptr_q : '0;
    assign flush_rob_tag_0_valid = flushing && (remaining_q != '0);
    assign flush_rob_tag_1_valid = flushing && (remaining_q != '0);

    // Slot 1 is older; the RAT applies slot 0 then slot 1 so the older old_preg wins.
    assign rat_restore_valid_0 = slot0_live && entry_0.wen;
    assign rat_restore_valid_1 = slot1_live && entry_1.wen;
    assign rat_restore_arch_0  = rat_restore_valid_0 ? entry_0.arch : '0;
    assign rat_restore_arch_1  = rat_restore_valid_1 ? entry_1.arch : '0;
    assign rat_restore_preg_0  = rat_restore_valid_0 ? entry_0.old_preg : '0;
    assign rat_restore_preg_1  = rat_restore_valid_1 ? entry_1.old_preg : '0;
    assign fl_return_valid_0   = rat_restore_valid_0;
    assign fl_return_valid_1   = rat_restore_valid_1;
    assign fl_return_preg_0    = rat_restore_valid_0 ? entry_0.new_preg : '0;
    assign fl_return_preg_1    = rat_restore_valid_1 ? entry_1.new_preg : '0;

    assign ROB_recovery_finished  = finish;
    assign rob_tail_restore_valid = finish;
    assign rob_tail_restore       = finish ? boundary_q : '0;

`ifdef RECOVERY_WALK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_recoveries  <= '0;
            stat_walk_cycles <= '0;
        end else begin
            if (accept && stat_recoveries != '1) stat_recoveries <= stat_recoveries + 32'd1;
            if (active && stat_walk_cycles != '1) stat_walk_cycles <= stat_walk_cycles + 32'd1;
        end
    end
`endif

    // A start outside IDLE is a controller protocol violation and is dropped.
    assert property (@(posedge clk) disable iff (!rst_n) recovery_start |-> state_q == ST_IDLE);

endmodule

// File: tb/tb_rob_recovery_walker.sv
// tb/tb_rob_recovery_walker.sv - randomized self-checking bench for rob_recovery_walker
module tb_rob_recovery_walker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       recovery_start, recovery_inclusive, rob_full, recovery_flush, recovery_rollback;
    logic [4:0] recovery_tag, rob_tail;
    logic [4:0] rob_rd_tag_0, rob_rd_tag_1;
    logic       rob_rd_wen_0, rob_rd_wen_1;
    logic [4:0] rob_rd_arch_0, rob_rd_arch_1;
    logic [5:0] rob_rd_old_preg_0, rob_rd_old_preg_1, rob_rd_new_preg_0, rob_rd_new_preg_1;
    logic [4:0] flush_rob_tag_0, flush_rob_tag_1;
    logic       flush_rob_tag_0_valid, flush_rob_tag_1_valid;
    logic       rat_restore_valid_0, rat_restore_valid_1;
    logic [4:0] rat_restore_arch_0, rat_restore_arch_1;
    logic [5:0] rat_restore_preg_0, rat_restore_preg_1;
    logic       fl_return_valid_0, fl_return_valid_1;
    logic [5:0] fl_return_preg_0, fl_return_preg_1;
    logic       rob_tail_restore_valid;
    logic [4:0] rob_tail_restore;
    logic       ROB_recovery_finished;
`ifdef RECOVERY_WALK_STATS_EN
    logic [31:0] stat_recoveries, stat_walk_cycles;
`endif

    logic       rob_wen  [32];
    logic [4:0] rob_arch [32];
    logic [5:0] rob_old  [32];
    logic [5:0] rob_new  [32];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rob_rd_wen_0      = rob_wen[rob_rd_tag_0];
    assign rob_rd_wen_1      = rob_wen[rob_rd_tag_1];
    assign rob_rd_arch_0     = rob_arch[rob_rd_tag_0];
    assign rob_rd_arch_1     = rob_arch[rob_rd_tag_1];
    assign rob_rd_old_preg_0 = rob_old[rob_rd_tag_0];
    assign rob_rd_old_preg_1 = rob_old[rob_rd_tag_1];
    assign rob_rd_new_preg_0 = rob_new[rob_rd_tag_0];
    assign rob_rd_new_preg_1 = rob_new[rob_rd_tag_1];

    rob_recovery_walker dut (
        .clk(clk), .rst_n(rst_n),
        .recovery_start(recovery_start), .recovery_tag(recovery_tag),
        .recovery_inclusive(recovery_inclusive), .rob_tail(rob_tail), .rob_full(rob_full),
        .recovery_flush(recovery_flush), .recovery_rollback(recovery_rollback),
        .rob_rd_tag_0(rob_rd_tag_0), .rob_rd_tag_1(rob_rd_tag_1),
        .rob_rd_wen_0(rob_rd_wen_0), .rob_rd_wen_1(rob_rd_wen_1),
        .rob_rd_arch_0(rob_rd_arch_0), .rob_rd_arch_1(rob_rd_arch_1),
        .rob_rd_old_preg_0(rob_rd_old_preg_0), .rob_rd_old_preg_1(rob_rd_old_preg_1),
        .rob_rd_new_preg_0(rob_rd_new_preg_0), .rob_rd_new_preg_1(rob_rd_new_preg_1),
        .flush_rob_tag_0(flush_rob_tag_0), .flush_rob_tag_1(flush_rob_tag_1),
        .flush_rob_tag_0_valid(flush_rob_tag_0_valid), .flush_rob_tag_1_valid(flush_rob_tag_1_valid),
        .rat_restore_valid_0(rat_restore_valid_0), .rat_restore_valid_1(rat_restore_valid_1),
        .rat_restore_arch_0(rat_restore_arch_0), .rat_restore_arch_1(rat_restore_arch_1),
        .rat_restore_preg_0(rat_restore_preg_0), .rat_restore_preg_1(rat_restore_preg_1),
        .fl_return_valid_0(fl_return_valid_0), .fl_return_valid_1(fl_return_valid_1),
        .fl_return_preg_0(fl_return_preg_0), .fl_return_preg_1(fl_return_preg_1),
        .rob_tail_restore_valid(rob_tail_restore_valid), .rob_tail_restore(rob_tail_restore),
`ifdef RECOVERY_WALK_STATS_EN
        .stat_recoveries(stat_recoveries), .stat_walk_cycles(stat_walk_cycles),
`endif
        .ROB_recovery_finished(ROB_recovery_finished)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill_rob(input int wen_pct);
        for (int i = 0; i < 32; i++) begin
            rob_wen[i]  = ($urandom_range(0, 99) < wen_pct);
            rob_arch[i] = 5'($urandom);
            rob_old[i]  = 6'($urandom);
            rob_new[i]  = 6'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rat0"}, {31'd0, rat_restore_valid_0}, 0);
        check({tag, "_rat1"}, {31'd0, rat_restore_valid_1}, 0);
        check({tag, "_fl0"}, {31'd0, fl_return_valid_0}, 0);
        check({tag, "_fl1"}, {31'd0, fl_return_valid_1}, 0);
        check({tag, "_fin"}, {31'd0, ROB_recovery_finished}, 0);
        check({tag, "_tailv"}, {31'd0, rob_tail_restore_valid}, 0);
    endtask

    task automatic check_slot(input int k, input int t);
        logic v;
        logic [4:0] a;
        logic [5:0] o, nw;
        v  = (k == 0) ? rat_restore_valid_0 : rat_restore_valid_1;
        a  = (k == 0) ? rat_restore_arch_0 : rat_restore_arch_1;
        o  = (k == 0) ? rat_restore_preg_0 : rat_restore_preg_1;
        nw = (k == 0) ? fl_return_preg_0 : fl_return_preg_1;
        check($sformatf("rat_v%0d_t%0d", k, t), {31'd0, v}, {31'd0, rob_wen[t]});
        check($sformatf("fl_v%0d_t%0d", k, t),
              {31'd0, (k == 0) ? fl_return_valid_0 : fl_return_valid_1}, {31'd0, rob_wen[t]});
        if (rob_wen[t]) begin
            check($sformatf("rat_arch%0d_t%0d", k, t), {27'd0, a}, {27'd0, rob_arch[t]});
            check($sformatf("rat_preg%0d_t%0d", k, t), {26'd0, o}, {26'd0, rob_old[t]});
            check($sformatf("fl_preg%0d_t%0d", k, t), {26'd0, nw}, {26'd0, rob_new[t]});
        end
    endtask

    // One full recovery: start, one flush cycle, rollback until finished.
    task automatic run_recovery(input int tag, input int incl, input int tail, input int full,
                                input int gap_at, input int reset_at, input int rand_gaps);
        int bnd, rem, n, rb_cycles, cyc, gap_left;
        int q[$];
        bit rb, done;
        bnd = incl ? tag : (tag + 1) % 32;
        rem = (tail - bnd + 32) % 32;
        if (full != 0 && rem == 0) rem = 32;
        for (int i = 0; i < rem; i++) q.push_back((tail - 1 - i + 64) % 32);

        @(negedge clk);
        recovery_start     = 1'b1;
        recovery_tag       = 5'(tag);
        recovery_inclusive = 1'(incl);
        rob_tail           = 5'(tail);
        rob_full           = 1'(full);
        @(negedge clk);
        recovery_start = 1'b0;
        rob_full       = 1'b0;
        #1;
        check("armed_idle_flushv", {31'd0, flush_rob_tag_0_valid}, 0);
        check_quiet("armed");
        @(negedge clk);
        recovery_flush = 1'b1;
        #1;
        check("flush_v0", {31'd0, flush_rob_tag_0_valid}, (rem != 0) ? 1 : 0);
        check("flush_v1", {31'd0, flush_rob_tag_1_valid}, (rem != 0) ? 1 : 0);
        check("flush_tag0", {27'd0, flush_rob_tag_0}, bnd);
        check("flush_tag1", {27'd0, flush_rob_tag_1}, (tail + 31) % 32);
        @(negedge clk);
        recovery_flush = 1'b0;

        rb_cycles = 0;
        cyc       = 0;
        gap_left  = 3;
        done      = 1'b0;
        while (!done && cyc < 120) begin
            cyc++;
            if (gap_at >= 0 && rb_cycles == gap_at && gap_left > 0) begin
                rb = 1'b0;
                gap_left--;
            end else if (rand_gaps != 0) begin
                rb = ($urandom_range(0, 3) != 0);
            end else begin
                rb = 1'b1;
            end
            recovery_rollback = rb;
            if (reset_at >= 0 && rb_cycles == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_quiet("rst_mid");
                check("rst_rdtag", {27'd0, rob_rd_tag_0}, 0);
                check("rst_flushv", {31'd0, flush_rob_tag_0_valid}, 0);
                @(negedge clk);
                recovery_rollback = 1'b0;
                #1;
                check_quiet("rst_hold");
                rst_n = 1'b1;
                return;
            end
            #1;
            if (rb) begin
                n = (q.size() < 2) ? q.size() : 2;
                if (n >= 1) begin
                    check("rd_tag0", {27'd0, rob_rd_tag_0}, q[0]);
                    check_slot(0, q[0]);
                end else begin
                    check("empty_rat0", {31'd0, rat_restore_valid_0}, 0);
                end
                if (n == 2) begin
                    check("rd_tag1", {27'd0, rob_rd_tag_1}, q[1]);
                    check_slot(1, q[1]);
                end else begin
                    check("short_rat1", {31'd0, rat_restore_valid_1}, 0);
                end
                done = (q.size() <= 2);
                check("finished", {31'd0, ROB_recovery_finished}, {31'd0, done});
                check("tail_v", {31'd0, rob_tail_restore_valid}, {31'd0, done});
                if (done) check("tail_restore", {27'd0, rob_tail_restore}, bnd);
                for (int i = 0; i < n; i++) void'(q.pop_front());
                rb_cycles++;
            end else begin
                check_quiet("rb_low");
            end
            @(negedge clk);
        end
        if (!done) check("walk_timeout", 1, 0);
        recovery_rollback = 1'b0;
        #1;
        check_quiet("after");
        check("walk_cycles", rb_cycles, (rem <= 2) ? 1 : (rem + 1) / 2);
    endtask

    initial begin
        rst_n              = 1'b0;
        recovery_start     = 1'b0;
        recovery_tag       = '0;
        recovery_inclusive = 1'b0;
        rob_tail           = '0;
        rob_full           = 1'b0;
        recovery_flush     = 1'b0;
        recovery_rollback  = 1'b0;
        fill_rob(70);
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_flushv", {31'd0, flush_rob_tag_1_valid}, 0);
        check("reset_tail", {27'd0, rob_tail_restore}, 0);
        check("reset_rdtag", {27'd0, rob_rd_tag_0}, 0);
        rst_n = 1'b1;

        run_recovery(5, 0, 10, 0, -1, -1, 0);
        run_recovery(5, 1, 6, 0, -1, -1, 0);
        run_recovery(30, 0, 2, 0, -1, -1, 0);
        run_recovery(9, 0, 10, 0, -1, -1, 0);
        fill_rob(50);
        run_recovery(3, 0, 4, 1, 5, -1, 0);

        fill_rob(70);
        rob_wen[19] = 1'b1; rob_arch[19] = 5'd3;
        rob_wen[18] = 1'b1; rob_arch[18] = 5'd3;
        run_recovery(15, 0, 20, 0, -1, -1, 0);
        run_recovery(0, 0, 16, 0, -1, 2, 0);
        run_recovery(7, 1, 12, 0, -1, -1, 0);

        for (int it = 0; it < 25; it++) begin
            fill_rob(int'($urandom_range(0, 100)));
            run_recovery(int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0) ? 1 : 0,
                         -1, -1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
